// File: rtl/prescaled_mod_counter.sv
// ---------------------------------------------------------------------------
// prescaled_mod_counter
//
// Purpose:
//   Parametrised prescaled modulo counter. A prescaler divides enabled clock
//   cycles by PRESCALE; every PRESCALE-th enabled cycle is a "step edge" on
//   which the count moves up or down by one inside the range 0..MODULUS-1.
//   In free-run mode the count wraps around. In one-shot mode the counter
//   stops at the terminal value and reports completion on done.
//   Synchronous clear and load take priority over stepping.
//
// Parameters:
//   WIDTH     count register width in bits
//   PRESCALE  enabled clk cycles per count step (1..1024)
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//
// Ports:
//   clk       clock
//   rst       asynchronous, active-high reset
//   en        count enable; low freezes prescaler and count
//   up_dn     1 = count up, 0 = count down (sampled on each step edge)
//   oneshot   1 = halt at the terminal value instead of wrapping
//   clr       synchronous clear (highest priority)
//   load      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  value for load
//   count     current count
//   tick      one-cycle pulse on every step edge
//   wrap      one-cycle pulse when a step is attempted from the terminal value
//   done      level; one-shot completed and counter halted
// ---------------------------------------------------------------------------
module prescaled_mod_counter #(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 101,
  parameter int MODULUS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             done
);

  // A single-cycle prescale still needs a one-bit register so the
  // comparison logic below stays uniform across all builds.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PTOP = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CTOP = WIDTH'(MODULUS - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [PW-1:0]    pcnt, pcnt_d;
  logic [WIDTH-1:0] count_d;
  logic             tick_d;
  logic             wrap_d;
  logic [WIDTH-1:0] load_clamped;

  // Loads never use modulo reduction: anything beyond the top of the
  // range saturates to the terminal value.
  assign load_clamped = (load_val > CTOP) ? CTOP : load_val;

  // done is simply the registered HALT state, so it changes on the same
  // edge as count, tick and wrap.
  assign done = (state == HALT);

  // State and output registers. Everything visible at the ports comes
  // straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pcnt  <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_d;
      pcnt  <= pcnt_d;
      count <= count_d;
      tick  <= tick_d;
      wrap  <= wrap_d;
    end
  end

  // Next-state logic. Priority is clr, then load, then the RUN/HALT
  // behaviour. Strobes default low so they only ever last one cycle
  // unless a step happens on every cycle.
  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    count_d = count;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    if (clr) begin
      state_d = RUN;
      pcnt_d  = '0;
      count_d = '0;
    end else if (load) begin
      state_d = RUN;
      pcnt_d  = '0;
      count_d = load_clamped;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (pcnt == PTOP) begin
              pcnt_d = '0;
              tick_d = 1'b1;
              // wrap marks a step attempted from the terminal value;
              // stepping into the terminal value is an ordinary step.
              if (up_dn) begin
                if (count == CTOP) begin
                  wrap_d = 1'b1;
                  if (oneshot) begin
                    state_d = HALT;
                  end else begin
                    count_d = '0;
                  end
                end else begin
                  count_d = count + WIDTH'(1);
                end
              end else begin
                if (count == '0) begin
                  wrap_d = 1'b1;
                  if (oneshot) begin
                    state_d = HALT;
                  end else begin
                    count_d = CTOP;
                  end
                end else begin
                  count_d = count - WIDTH'(1);
                end
              end
            end else begin
              pcnt_d = pcnt + PW'(1);
            end
          end
        end
        HALT: begin
          pcnt_d = '0;
        end
        default: begin
          state_d = RUN;
          pcnt_d  = '0;
        end
      endcase
    end
  end

endmodule
